// File: rtl/xdisp_ctrl.sv
// rtl/xdisp_ctrl.sv - memory-mapped 4-digit seven-segment scan controller
// Bus-written value/masks are shadowed at frame start; digits are time-multiplexed with blanking.
module xdisp_ctrl #(
  parameter int DATA_W    = 32,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic              we,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic [7:0]        Disp,
  output logic [3:0]        Disp_sel
);
  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       digit_q, digit_d;
  logic             load_sh, frame_inc;
  logic [15:0]      value_q, val_sh, frame_q;
  logic             en_q;
  logic [3:0]       dp_q, bm_q, dp_sh, bm_sh;
  logic [7:0]       disp_d;
  logic [3:0]       sel_d;
  logic [31:0]      rd32;
  logic             unused_bits;

  assign unused_bits = ^{data_in[DATA_W-1:12], data_in[3:1]};

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;  4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;  4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;  4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;  4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    digit_d   = digit_q;
    load_sh   = 1'b0;
    frame_inc = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        digit_d = 2'd0;
        if (en_q) begin
          state_d = BLANK;
          load_sh = 1'b1;
        end
      end
      BLANK: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == BLANK_LAST) state_d = DRIVE;
      end
      DRIVE: begin
        if (cnt_q == SLOT_LAST) begin
          cnt_d   = '0;
          digit_d = digit_q + 2'd1;
          state_d = BLANK;
          if (digit_q == 2'd3) begin
            frame_inc = 1'b1;
            load_sh   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (!en_q) begin
      state_d   = IDLE;
      cnt_d     = '0;
      digit_d   = 2'd0;
      load_sh   = 1'b0;
      frame_inc = 1'b0;
    end
  end

  // Outputs are computed from the next state so they line up with the state register.
  always_comb begin
    disp_d = 8'hFF;
    sel_d  = 4'hF;
    if (state_d == DRIVE) begin
      sel_d  = bm_sh[digit_d] ? 4'hF : ~(4'b0001 << digit_d);
      disp_d = {~dp_sh[digit_d], seg7(val_sh[{digit_d, 2'b00} +: 4])};
    end
  end

  always_comb begin
    rd32 = 32'h0;
    case (addr)
      2'd0:    rd32 = {16'h0, value_q};
      2'd1:    rd32 = {20'h0, bm_q, dp_q, 3'b000, en_q};
      2'd2:    rd32 = {frame_q, 13'h0, state_q == DRIVE, digit_q};
      default: rd32 = 32'h0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      digit_q  <= 2'd0;
      value_q  <= 16'h0;
      en_q     <= 1'b0;
      dp_q     <= 4'h0;
      bm_q     <= 4'h0;
      val_sh   <= 16'h0;
      dp_sh    <= 4'h0;
      bm_sh    <= 4'h0;
      frame_q  <= 16'h0;
      data_out <= '0;
      Disp     <= 8'hFF;
      Disp_sel <= 4'hF;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      digit_q  <= digit_d;
      Disp     <= disp_d;
      Disp_sel <= sel_d;
      if (load_sh) begin
        val_sh <= value_q;
        dp_sh  <= dp_q;
        bm_sh  <= bm_q;
      end
      if (frame_inc) frame_q <= frame_q + 16'd1;
      if (sel && we) begin
        case (addr)
          2'd0: value_q <= data_in[15:0];
          2'd1: begin
            en_q <= data_in[0];
            dp_q <= data_in[7:4];
            bm_q <= data_in[11:8];
          end
          default: ;
        endcase
      end
      if (sel && !we) data_out <= DATA_W'(rd32);
    end
  end
endmodule

// File: tb/tb_xdisp_ctrl.sv
// tb/tb_xdisp_ctrl.sv - scoreboard bench for xdisp_ctrl
module tb_xdisp_ctrl;
  logic        clk = 1'b0;
  logic        rst, sel, we;
  logic [1:0]  addr;
  logic [31:0] data_in, data_out;
  logic [7:0]  Disp;
  logic [3:0]  Disp_sel;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [11:0] exp_q[$];
  logic [11:0] e;
  logic [31:0] v;

  always #5 clk = ~clk;

  xdisp_ctrl #(.DATA_W(32), .SCAN_DIV(8), .BLANK_CYC(2)) dut (
    .clk(clk), .rst(rst), .sel(sel), .we(we), .addr(addr),
    .data_in(data_in), .data_out(data_out), .Disp(Disp), .Disp_sel(Disp_sel)
  );

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [7:0] g;
    case (n)
      4'h0: g = 8'hC0;  4'h1: g = 8'hF9;  4'h2: g = 8'hA4;  4'h3: g = 8'hB0;
      4'h4: g = 8'h99;  4'h5: g = 8'h92;  4'h6: g = 8'h82;  4'h7: g = 8'hF8;
      4'h8: g = 8'h80;  4'h9: g = 8'h90;  4'hA: g = 8'h88;  4'hB: g = 8'h83;
      4'hC: g = 8'hC6;  4'hD: g = 8'hA1;  4'hE: g = 8'h86;  default: g = 8'h8E;
    endcase
    return g[6:0];
  endfunction

  function automatic logic [3:0] anode(input int d);
    case (d)
      0: return 4'hE;
      1: return 4'hD;
      2: return 4'hB;
      default: return 4'h7;
    endcase
  endfunction

  task automatic push_idle(input int n);
    repeat (n) exp_q.push_back({4'hF, 8'hFF});
  endtask

  task automatic push_frame(input logic [15:0] val, input logic [3:0] dp, input logic [3:0] bm);
    for (int d = 0; d < 4; d++) begin
      push_idle(2);
      repeat (6) exp_q.push_back({bm[d] ? 4'hF : anode(d), ~dp[d], glyph(val[4*d +: 4])});
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; addr = a; data_in = d;
    @(posedge clk); #1;
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] q);
    sel = 1'b1; we = 1'b0; addr = a;
    @(posedge clk); #1;
    sel = 1'b0;
    q = data_out;
  endtask

  task automatic start(input logic [15:0] val, input logic [31:0] ctrl);
    wr(2'd1, 32'h0);
    wr(2'd0, {16'h0, val});
    wr(2'd1, ctrl);
  endtask

  task automatic test_reset;
    rst = 1'b1; sel = 1'b0; we = 1'b0; addr = 2'd0; data_in = 32'h0;
    @(posedge clk); #1;
    n_vec++;
    if ({Disp_sel, Disp, data_out} !== {4'hF, 8'hFF, 32'h0}) begin
      n_bad++;
      $display("FAIL reset_hold: got %h/%h/%h expected F/FF/0", Disp_sel, Disp, data_out);
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_vec++;
      if ({Disp_sel, Disp, data_out} !== {4'hF, 8'hFF, 32'h0}) begin
        n_bad++;
        $display("FAIL reset_idle[%0d]: got %h/%h/%h expected F/FF/0", i, Disp_sel, Disp, data_out);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic_scan;
    start(16'h1234, 32'h1);
    push_idle(1);
    push_frame(16'h1234, 4'h0, 4'h0);
    push_frame(16'h1234, 4'h0, 4'h0);
    fork
      while (exp_q.size() != 0) begin
        @(negedge clk);
        e = exp_q.pop_front();
        n_vec++;
        if ({Disp_sel, Disp} !== e) begin
          n_bad++;
          $display("FAIL basic_scan: got %h/%h expected %h/%h", Disp_sel, Disp, e[11:8], e[7:0]);
        end
      end
      begin
        repeat (39) @(posedge clk);
        #1;
        rd(2'd2, v);
      end
    join
    n_vec++;
    if (v !== 32'h0001_0004) begin
      n_bad++;
      $display("FAIL basic_status: got %h expected 00010004", v);
    end
  endtask

  task automatic test_tear_free;
    start(16'h1234, 32'h1);
    push_idle(1);
    push_frame(16'h1234, 4'h0, 4'h0);
    push_frame(16'hABCD, 4'h0, 4'h0);
    fork
      while (exp_q.size() != 0) begin
        @(negedge clk);
        e = exp_q.pop_front();
        n_vec++;
        if ({Disp_sel, Disp} !== e) begin
          n_bad++;
          $display("FAIL tear_mid: got %h/%h expected %h/%h", Disp_sel, Disp, e[11:8], e[7:0]);
        end
      end
      begin
        repeat (11) @(posedge clk);
        #1;
        wr(2'd0, 32'hABCD);
      end
    join
    start(16'h1234, 32'h1);
    push_idle(1);
    push_frame(16'h1234, 4'h0, 4'h0);
    push_frame(16'h1234, 4'h0, 4'h0);
    push_frame(16'hABCD, 4'h0, 4'h0);
    fork
      while (exp_q.size() != 0) begin
        @(negedge clk);
        e = exp_q.pop_front();
        n_vec++;
        if ({Disp_sel, Disp} !== e) begin
          n_bad++;
          $display("FAIL tear_wrap: got %h/%h expected %h/%h", Disp_sel, Disp, e[11:8], e[7:0]);
        end
      end
      begin
        repeat (32) @(posedge clk);
        #1;
        wr(2'd0, 32'hABCD);
      end
    join
  endtask

  task automatic test_masks;
    logic [31:0] ctrls [2];
    ctrls[0] = 32'h0251;
    ctrls[1] = 32'h0421;
    for (int k = 0; k < 2; k++) begin
      start(16'h1234, ctrls[k]);
      push_idle(1);
      push_frame(16'h1234, ctrls[k][7:4], ctrls[k][11:8]);
      while (exp_q.size() != 0) begin
        @(negedge clk);
        e = exp_q.pop_front();
        n_vec++;
        if ({Disp_sel, Disp} !== e) begin
          n_bad++;
          $display("FAIL masks[%0d]: got %h/%h expected %h/%h", k, Disp_sel, Disp, e[11:8], e[7:0]);
        end
      end
      rd(2'd1, v);
      n_vec++;
      if (v !== ctrls[k]) begin
        n_bad++;
        $display("FAIL ctrl_readback[%0d]: got %h expected %h", k, v, ctrls[k]);
      end
    end
  endtask

  task automatic test_disable_read;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    start(16'h1234, 32'h1);
    push_idle(1);
    push_frame(16'h1234, 4'h0, 4'h0);
    push_idle(2);
    repeat (4) exp_q.push_back({4'hE, 1'b1, glyph(4'h4)});
    push_idle(4);
    fork
      while (exp_q.size() != 0) begin
        @(negedge clk);
        e = exp_q.pop_front();
        n_vec++;
        if ({Disp_sel, Disp} !== e) begin
          n_bad++;
          $display("FAIL disable: got %h/%h expected %h/%h", Disp_sel, Disp, e[11:8], e[7:0]);
        end
      end
      begin
        repeat (37) @(posedge clk);
        #1;
        wr(2'd1, 32'h0);
      end
    join
    rd(2'd2, v);
    n_vec++;
    if (v !== 32'h0001_0000) begin
      n_bad++;
      $display("FAIL status_idle: got %h expected 00010000", v);
    end
    wr(2'd2, 32'hFFFF_FFFF);
    rd(2'd2, v);
    n_vec++;
    if (v !== 32'h0001_0000) begin
      n_bad++;
      $display("FAIL status_write: got %h expected 00010000", v);
    end
    rd(2'd3, v);
    n_vec++;
    if (v !== 32'h0) begin
      n_bad++;
      $display("FAIL addr3_read: got %h expected 0", v);
    end
    wr(2'd3, 32'hFFFF_FFFF);
    rd(2'd3, v);
    n_vec++;
    if (v !== 32'h0) begin
      n_bad++;
      $display("FAIL addr3_write: got %h expected 0", v);
    end
    rd(2'd0, v);
    n_vec++;
    if (v !== 32'h1234) begin
      n_bad++;
      $display("FAIL value_readback: got %h expected 1234", v);
    end
  endtask

  task automatic test_async_reset;
    start(16'h1234, 32'h1);
    push_idle(3);
    exp_q.push_back({4'hE, 1'b1, glyph(4'h4)});
    while (exp_q.size() != 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_vec++;
      if ({Disp_sel, Disp} !== e) begin
        n_bad++;
        $display("FAIL pre_reset: got %h/%h expected %h/%h", Disp_sel, Disp, e[11:8], e[7:0]);
      end
    end
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    n_vec++;
    if ({Disp_sel, Disp, data_out} !== {4'hF, 8'hFF, 32'h0}) begin
      n_bad++;
      $display("FAIL async_reset: got %h/%h/%h expected F/FF/0", Disp_sel, Disp, data_out);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    push_idle(10);
    while (exp_q.size() != 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_vec++;
      if ({Disp_sel, Disp} !== e) begin
        n_bad++;
        $display("FAIL post_reset_idle: got %h/%h expected %h/%h", Disp_sel, Disp, e[11:8], e[7:0]);
      end
    end
    wr(2'd1, 32'h1);
    push_idle(1);
    push_frame(16'h0000, 4'h0, 4'h0);
    while (exp_q.size() != 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_vec++;
      if ({Disp_sel, Disp} !== e) begin
        n_bad++;
        $display("FAIL reenable: got %h/%h expected %h/%h", Disp_sel, Disp, e[11:8], e[7:0]);
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic_scan;
    test_tear_free;
    test_masks;
    test_disable_read;
    test_async_reset;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
